// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file.
//   clr_state_t : states of the bulk-clear sequencer
//   ZERO_IDX    : index of the hardwired-zero entry
//   field_lsb   : bit offset of field `port` inside a flattened per-port bus
package regfile_pkg;

    typedef enum logic [1:0] {
        CLR_IDLE  = 2'd0,
        CLR_CLEAR = 2'd1,
        CLR_DONE  = 2'd2
    } clr_state_t;

    localparam int ZERO_IDX = 0;

    // Ports are packed side by side; port k occupies [k*width +: width].
    function automatic int field_lsb(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp.
//   rd_addr/rd_data/rd_pend : flattened read ports (port k in slice k)
//   wr_en/wr_addr/wr_data   : writeback port
//   pend_set/pend_addr      : issue-side scoreboard set
//   clr_start/busy/done     : bulk-clear control and status
//   clr_state               : clear sequencer state, debug visibility only
// Handshake: there is no ready path. A write or pend_set is taken on the
// rising edge where it is asserted unless clr_busy is high in that cycle,
// in which case it is silently dropped; clr_start is only honoured while
// the sequencer is idle (clr_busy and clr_done both low).
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) ();
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_pend;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     pend_set;
    logic [ADDR_W-1:0]        pend_addr;
    logic                     clr_start;
    logic                     clr_busy;
    logic                     clr_done;
    clr_state_t               clr_state;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, pend_set, pend_addr, clr_start,
        input  rd_data, rd_pend, clr_busy, clr_done, clr_state
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, pend_set, pend_addr, clr_start,
        output rd_data, rd_pend, clr_busy, clr_done, clr_state
    );
endinterface

// File: rtl/regfile_clear_seq.sv
// Bulk-clear sequencer: walks every entry index once, one per clock.
//   clk, reset : clock, async active-high reset
//   clr_start  : start request, honoured only in IDLE
//   clr_busy   : high while sweeping (CLEAR)
//   clr_done   : single-cycle pulse after the last entry (DONE)
//   clr_we     : zero-write strobe for entry clr_idx
//   clr_idx    : entry being cleared this cycle
//   state      : current sequencer state (debug)
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_idx,
    output clr_state_t        state
);
    logic [ADDR_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= CLR_IDLE;
            cnt      <= '0;
            clr_busy <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            case (state)
                CLR_IDLE: begin
                    if (clr_start) begin
                        state    <= CLR_CLEAR;
                        cnt      <= '0;
                        clr_busy <= 1'b1;
                    end
                end
                CLR_CLEAR: begin
                    // Counter wraps to 0 naturally after the last entry.
                    cnt <= cnt + 1'b1;
                    if (cnt == '1) begin
                        state    <= CLR_DONE;
                        clr_busy <= 1'b0;
                        clr_done <= 1'b1;
                    end
                end
                CLR_DONE: begin
                    state    <= CLR_IDLE;
                    clr_done <= 1'b0;
                end
                default: begin
                    state    <= CLR_IDLE;
                    clr_busy <= 1'b0;
                    clr_done <= 1'b0;
                end
            endcase
        end
    end

    assign clr_we  = clr_busy;
    assign clr_idx = cnt;
endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with hardwired zero entry, write-to-read
// bypass, per-entry pending (scoreboard) bits and a bulk-clear engine.
//   clk, reset : clock, async active-high reset (clears array and pending)
//   bus        : regfile_mp_if slave (read ports, write, pend_set, clear)
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input logic         clk,
    input logic         reset,
    regfile_mp_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  pend;

    logic              clr_busy;
    logic              clr_done;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_idx;
    clr_state_t        clr_state;
    logic              wr_acc;
    logic              pend_acc;

    regfile_clear_seq #(.ADDR_W(ADDR_W)) u_clear (
        .clk       (clk),
        .reset     (reset),
        .clr_start (bus.clr_start),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .clr_we    (clr_we),
        .clr_idx   (clr_idx),
        .state     (clr_state)
    );

    assign bus.clr_busy  = clr_busy;
    assign bus.clr_done  = clr_done;
    assign bus.clr_state = clr_state;

    assign wr_acc   = bus.wr_en && !clr_busy &&
                      !(ZERO_REG && bus.wr_addr == ADDR_W'(ZERO_IDX));
    assign pend_acc = bus.pend_set && !clr_busy &&
                      !(ZERO_REG && bus.pend_addr == ADDR_W'(ZERO_IDX));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            pend <= '0;
        end else if (clr_we) begin
            mem[clr_idx]  <= '0;
            pend[clr_idx] <= 1'b0;
        end else begin
            if (wr_acc) begin
                mem[bus.wr_addr]  <= bus.wr_data;
                pend[bus.wr_addr] <= 1'b0;
            end
            // Placed after the write so a same-address set wins: a new
            // producer was issued while the old result retired.
            if (pend_acc) begin
                pend[bus.pend_addr] <= 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              is_zero;
        logic [DATA_W-1:0] data;

        assign addr    = bus.rd_addr[field_lsb(k, ADDR_W) +: ADDR_W];
        assign is_zero = ZERO_REG && (addr == ADDR_W'(ZERO_IDX));

        always_comb begin
            data = mem[addr];
            if (is_zero) begin
                data = '0;
            end else if (BYPASS && wr_acc && bus.wr_addr == addr) begin
                data = bus.wr_data;
            end
        end

        assign bus.rd_data[field_lsb(k, DATA_W) +: DATA_W] = data;
        // Pending is never bypassed: decode sees the registered scoreboard.
        assign bus.rd_pend[k] = is_zero ? 1'b0 : pend[addr];
    end
endmodule
